cmd_serial_to_parallel: RTL
===========================

Name: cmd_serial_to_parallel

Overview:
- CMD-line receive stage of the SD host physical layer. It sits directly upstream of the CMD physical-layer controller.
- When enabled by the controller's enable_stp_wrapper, it waits for a card response start bit on the CMD pad and shifts in a 48-bit or 136-bit frame MSB-first.
- It checks the end bit and CRC7, then delivers the frame to the controller's pad_response, reception_complete and no_response inputs.

Parameters:
- NCR_MAX, 64, maximum sd_clock samples waited for a start bit before declaring no response (1..255).
- LONG_LEN, 136, long (R2) frame length in bits.
- SHORT_LEN, 48, short (R1/R3/R6/R7) frame length in bits.

Ports:
- sd_clock  input  1  the single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable_stp  input  1  receive enable from the controller (its enable_stp_wrapper); level-sensitive.
- long_response  input  1  1 = expect 136-bit frame, 0 = 48-bit; sampled when leaving IDLE.
- cmd_in  input  1  serial CMD pad data.
- pad_response  output  136  received frame. 48-bit frames are right-aligned in [47:0] with [135:48] = 0.
- reception_complete  output  1  frame received; level.
- no_response  output  1  start-bit timeout; level.
- crc_error  output  1  CRC7 mismatch or end bit = 0; valid while reception_complete = 1.

Behaviour:
- Reset: while reset = 0 at an edge, all outputs become 0, the state goes to IDLE and the counters and shift register are cleared. This takes priority over everything, including mid-frame.
- States: IDLE, WAIT_START, RECEIVE, CHECK, DONE.
- IDLE:
  - Flags are held at 0; pad_response keeps its last loaded value.
  - If enable_stp = 1: latch long_response as len_sel, clear bit_cnt, ncr_cnt and the CRC register, then go to WAIT_START.
- WAIT_START:
  - If cmd_in = 0: this sample is frame bit 1 (the start bit). Shift it in, set bit_cnt = 1, go to RECEIVE. The CRC window excludes the start bit only for long frames (see CRC).
  - Else if ncr_cnt = NCR_MAX-1: set no_response = 1, go to DONE (exactly NCR_MAX high samples are tolerated).
  - Else: ncr_cnt increments.
- RECEIVE:
  - Each edge shifts cmd_in into the shift register LSB and increments bit_cnt.
  - When the sample making bit_cnt = len (48 or 136) is taken, go to CHECK.
- CHECK (1 cycle):
  - Load pad_response from the shift register (zero-extended for short frames).
  - crc_error = (computed CRC7 != frame bits [7:1]) OR (frame bit 0 = 0).
  - reception_complete = 1; go to DONE.
  - Latency: reception_complete is visible one edge after the edge that sampled the end bit.
- DONE:
  - Hold all outputs.
  - When enable_stp = 0: clear reception_complete, no_response and crc_error, and go to IDLE.
  - A new frame requires enable_stp to be low for at least one cycle.
- CRC:
  - CRC7, polynomial x^7+x^3+1, initial value 0, computed serially on arrival.
  - Short frames: covers frame bits 47..8 (start bit included).
  - Long frames: covers bits 127..8 (start, transmission and reserved bits 135..128 excluded).
  - Bits 7..0 are never fed into the CRC.
- Abort: if enable_stp = 0 in WAIT_START, RECEIVE or CHECK, go to IDLE next edge with flags at 0 and pad_response unchanged. CHECK takes its transition before DONE.
- Widths: bit_cnt is 8 bits (max 136); ncr_cnt is clog2(NCR_MAX) bits. No wrap is possible, since both counters are bounded by the state transitions.
- cmd_in is assumed already synchronised at the pad wrapper; no internal synchroniser.

Decomposition:
- Package sd_cmd_pkg:
  - state enum;
  - CMD_SHORT_LEN = 48, CMD_LONG_LEN = 136;
  - CRC7_POLY = 7'h09;
  - CRC window bounds per frame length.
- One sub-module, crc7_serial:
  - ports: sd_clock, reset, clear, enable, bit_in, crc[6:0];
  - one bit per enabled cycle;
  - reused later by the transmit (parallel-to-serial) stage.

Test Plan:
1. Short good frame: enable_stp = 1, long_response = 0; after 5 high cycles, drive 48'h40_0000_0000_95 MSB-first. Required: reception_complete = 1 one edge after the last bit, pad_response = 136'h...40_0000_0000_95, crc_error = 0, no_response = 0.
2. CRC/end-bit fault: same stimulus with 48'h400000000097 → crc_error = 1. With 48'h400000000094 → crc_error = 1 (end bit 0).
3. Timeout: enable_stp = 1 with cmd_in held 1 → no_response = 1 after exactly NCR_MAX = 64 samples, reception_complete = 0. A start bit on sample 64 instead is accepted.
4. Long frame: long_response = 1, 136-bit frame with bits 135..128 = 8'h3F, a random 120-bit body with matching CRC7 and end bit 1 → full 136-bit pad_response, crc_error = 0. Flip one body bit → crc_error = 1.
5. Abort and reset: drop enable_stp at bit 20 → IDLE, flags 0, pad_response unchanged. Assert reset = 0 at bit 30 of a new frame → all outputs 0 after that edge. A subsequent frame is received correctly.
6. Handshake: keep enable_stp high in DONE for 10 cycles → outputs held. Deassert → flags clear next edge. Re-enable → the next frame is received.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD host CMD-line stages (receive and transmit).
// Frame lengths, CRC7 generator and the CRC coverage window per frame type.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    CHECK,
    DONE
  } cmd_rx_state_t;

  localparam int CMD_SHORT_LEN = 48;
  localparam int CMD_LONG_LEN  = 136;

  // x^7 + x^3 + 1 without the implicit x^7 term
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Bits below CRC_WIN_LO (CRC field and end bit) never enter the CRC.
  // Long frames also skip their top CRC_LONG_HDR bits (start, transmission, reserved).
  localparam int CRC_WIN_LO   = 8;
  localparam int CRC_LONG_HDR = 8;

endpackage

// File: rtl/crc7_serial.sv
// Serial CRC7 generator, one bit per enabled cycle, MSB-first.
// Shared by the CMD receive and transmit stages.
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge sd_clock) begin
    if (!reset)      crc <= '0;
    else if (clear)  crc <= '0;
    else if (enable) crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
  end

endmodule

// File: rtl/cmd_serial_to_parallel.sv
// CMD-line receiver: waits for a response start bit, shifts in a 48/136-bit frame,
// checks CRC7 and end bit, and holds the result until the controller drops enable.
module cmd_serial_to_parallel
  import sd_cmd_pkg::*;
#(
  parameter int NCR_MAX   = 64,
  parameter int LONG_LEN  = CMD_LONG_LEN,
  parameter int SHORT_LEN = CMD_SHORT_LEN
) (
  input  logic                sd_clock,
  input  logic                reset,
  input  logic                enable_stp,
  input  logic                long_response,
  input  logic                cmd_in,
  output logic [LONG_LEN-1:0] pad_response,
  output logic                reception_complete,
  output logic                no_response,
  output logic                crc_error
);

  localparam int NCR_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;

  cmd_rx_state_t       state;
  logic                len_sel;
  logic [7:0]          bit_cnt;
  logic [NCR_W-1:0]    ncr_cnt;
  logic [LONG_LEN-1:0] shift_reg;
  logic [6:0]          crc;

  logic [7:0] len, next_cnt, bit_idx, win_hi;
  logic       shift_en, crc_en, crc_clr;

  // bit_cnt is 0 in WAIT_START, so bit_idx also gives the start bit's frame position
  assign len      = len_sel ? 8'(LONG_LEN) : 8'(SHORT_LEN);
  assign win_hi   = len_sel ? 8'(LONG_LEN - 1 - CRC_LONG_HDR) : 8'(SHORT_LEN - 1);
  assign next_cnt = bit_cnt + 8'd1;
  assign bit_idx  = len - next_cnt;

  assign shift_en = enable_stp &&
                    ((state == WAIT_START && !cmd_in) || state == RECEIVE);
  assign crc_en   = shift_en && (bit_idx >= 8'(CRC_WIN_LO)) && (bit_idx <= win_hi);
  assign crc_clr  = (state == IDLE) && enable_stp;

  crc7_serial u_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clr),
    .enable   (crc_en),
    .bit_in   (cmd_in),
    .crc      (crc)
  );

  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      state              <= IDLE;
      len_sel            <= 1'b0;
      bit_cnt            <= '0;
      ncr_cnt            <= '0;
      shift_reg          <= '0;
      pad_response       <= '0;
      reception_complete <= 1'b0;
      no_response        <= 1'b0;
      crc_error          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          reception_complete <= 1'b0;
          no_response        <= 1'b0;
          crc_error          <= 1'b0;
          if (enable_stp) begin
            len_sel   <= long_response;
            bit_cnt   <= '0;
            ncr_cnt   <= '0;
            shift_reg <= '0;
            state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (!enable_stp) begin
            state <= IDLE;
          end else if (!cmd_in) begin
            shift_reg <= {shift_reg[LONG_LEN-2:0], cmd_in};
            bit_cnt   <= 8'd1;
            state     <= RECEIVE;
          end else if (ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
            no_response <= 1'b1;
            state       <= DONE;
          end else begin
            ncr_cnt <= ncr_cnt + 1'b1;
          end
        end
        RECEIVE: begin
          if (!enable_stp) begin
            state <= IDLE;
          end else begin
            shift_reg <= {shift_reg[LONG_LEN-2:0], cmd_in};
            bit_cnt   <= next_cnt;
            if (next_cnt == len) state <= CHECK;
          end
        end
        CHECK: begin
          if (!enable_stp) begin
            state <= IDLE;
          end else begin
            pad_response <= len_sel ? shift_reg
                          : {{(LONG_LEN-SHORT_LEN){1'b0}}, shift_reg[SHORT_LEN-1:0]};
            crc_error          <= (crc != shift_reg[7:1]) || !shift_reg[0];
            reception_complete <= 1'b1;
            state              <= DONE;
          end
        end
        DONE: begin
          if (!enable_stp) begin
            reception_complete <= 1'b0;
            no_response        <= 1'b0;
            crc_error          <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
